// File: rtl/score_digit_scheduler.sv
// score_digit_scheduler
//
// Purpose:
//   Converts the binary score and high-score values into packed BCD digit
//   buffers for the on-screen text renderer. A single iterative double-dabble
//   engine is time-shared between the two channels. Conversion rounds start
//   only on a frame-start pulse, and each digit buffer is written in one
//   cycle, so the renderer never sees a half-updated value.
//
// Ports:
//   clk                in  system clock
//   rst                in  synchronous reset, active-high
//   frame_start        in  one-cycle pulse at the start of vertical blanking
//   score              in  current score, binary (VALUE_W bits)
//   high_score         in  current high score, binary (VALUE_W bits)
//   score_digits       out BCD score, most-significant digit in top nibble
//   high_score_digits  out BCD high score, same layout as score_digits
//   busy               out high whenever the scheduler is not idle
//   update_done        out one-cycle pulse when a scheduling round ends

module score_digit_scheduler #(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4,
  parameter int MAX_VALUE  = 9999
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [VALUE_W-1:0]      score,
  input  logic [VALUE_W-1:0]      high_score,
  output logic [4*NUM_DIGITS-1:0] score_digits,
  output logic [4*NUM_DIGITS-1:0] high_score_digits,
  output logic                    busy,
  output logic                    update_done
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int ITER_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

  localparam logic [VALUE_W-1:0] SAT_VALUE = VALUE_W'(MAX_VALUE);
  localparam logic [ITER_W-1:0]  LAST_ITER = ITER_W'(VALUE_W - 1);
  localparam logic [BCD_W-1:0]   ALL_NINES = {NUM_DIGITS{4'h9}};

  localparam logic CH_SCORE = 1'b0;
  localparam logic CH_HIGH  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_STORE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Double-dabble correction step: every BCD nibble of 5 or more gets +3 so
  // that the following left shift carries correctly into the next digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd_in);
    logic [BCD_W-1:0] adj;
    adj = bcd_in;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd_in[4*i +: 4];
      end
    end
    return adj;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,        state_d;
  logic                pending_q,      pending_d;
  logic                sel_q,          sel_d;

  // Values captured at the trigger; the round works only from these.
  logic [VALUE_W-1:0]  snap_score_q,   snap_score_d;
  logic [VALUE_W-1:0]  snap_high_q,    snap_high_d;

  // Last value actually written to each digit buffer.
  logic [VALUE_W-1:0]  last_score_q,   last_score_d;
  logic [VALUE_W-1:0]  last_high_q,    last_high_d;
  logic                valid_score_q,  valid_score_d;
  logic                valid_high_q,   valid_high_d;
  logic                dirty_score_q,  dirty_score_d;
  logic                dirty_high_q,   dirty_high_d;

  // Shared conversion engine.
  logic [BCD_W-1:0]    bcd_q,          bcd_d;
  logic [VALUE_W-1:0]  bin_q,          bin_d;
  logic [ITER_W-1:0]   iter_q,         iter_d;

  // Registered outputs.
  logic [BCD_W-1:0]    score_digits_q, score_digits_d;
  logic [BCD_W-1:0]    high_digits_q,  high_digits_d;
  logic                busy_q,         busy_d;
  logic                update_done_q,  update_done_d;

  // Combinational helpers.
  logic [VALUE_W-1:0]  pick_s;
  logic [BCD_W-1:0]    adj_s;

  // Next-state, datapath and output computation for the scheduler FSM.
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    sel_d          = sel_q;
    snap_score_d   = snap_score_q;
    snap_high_d    = snap_high_q;
    last_score_d   = last_score_q;
    last_high_d    = last_high_q;
    valid_score_d  = valid_score_q;
    valid_high_d   = valid_high_q;
    dirty_score_d  = dirty_score_q;
    dirty_high_d   = dirty_high_q;
    bcd_d          = bcd_q;
    bin_d          = bin_q;
    iter_d         = iter_q;
    score_digits_d = score_digits_q;
    high_digits_d  = high_digits_q;
    pick_s         = '0;
    adj_s          = '0;

    // A frame_start arriving mid-round (DONE included) is remembered so that
    // the next round starts as soon as the FSM is back in IDLE. Repeated
    // pulses simply keep the flag set.
    if (frame_start && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start || pending_q) begin
          snap_score_d  = score;
          snap_high_d   = high_score;
          pending_d     = 1'b0;
          // An invalid channel must be converted even if its value happens
          // to match the (reset) last value.
          dirty_score_d = (score != last_score_q) || !valid_score_q;
          dirty_high_d  = (high_score != last_high_q) || !valid_high_q;
          state_d       = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SELECT: begin
        if (dirty_score_q || dirty_high_q) begin
          sel_d  = dirty_score_q ? CH_SCORE : CH_HIGH;
          pick_s = dirty_score_q ? snap_score_q : snap_high_q;
          iter_d = '0;
          if (pick_s >= SAT_VALUE) begin
            // Saturated values skip the engine entirely.
            bcd_d   = ALL_NINES;
            bin_d   = '0;
            state_d = ST_STORE;
          end else begin
            bcd_d   = '0;
            bin_d   = pick_s;
            state_d = ST_CONVERT;
          end
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_CONVERT: begin
        adj_s = dabble_adjust(bcd_q);
        bcd_d = {adj_s[BCD_W-2:0], bin_q[VALUE_W-1]};
        bin_d = {bin_q[VALUE_W-2:0], 1'b0};
        if (iter_q == LAST_ITER) begin
          state_d = ST_STORE;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = ST_CONVERT;
        end
      end

      ST_STORE: begin
        // Whole-buffer write: the renderer sees either the old or the new
        // value, never a partially shifted one.
        if (sel_q == CH_SCORE) begin
          score_digits_d = bcd_q;
          last_score_d   = snap_score_q;
          valid_score_d  = 1'b1;
          dirty_score_d  = 1'b0;
        end else begin
          high_digits_d  = bcd_q;
          last_high_d    = snap_high_q;
          valid_high_d   = 1'b1;
          dirty_high_d   = 1'b0;
        end
        state_d = ST_SELECT;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    busy_d        = (state_d != ST_IDLE);
    update_done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset; reset aborts any
  // round in flight without touching the digit buffers beyond clearing them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      sel_q          <= CH_SCORE;
      snap_score_q   <= '0;
      snap_high_q    <= '0;
      last_score_q   <= '0;
      last_high_q    <= '0;
      valid_score_q  <= 1'b0;
      valid_high_q   <= 1'b0;
      dirty_score_q  <= 1'b0;
      dirty_high_q   <= 1'b0;
      bcd_q          <= '0;
      bin_q          <= '0;
      iter_q         <= '0;
      score_digits_q <= '0;
      high_digits_q  <= '0;
      busy_q         <= 1'b0;
      update_done_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      sel_q          <= sel_d;
      snap_score_q   <= snap_score_d;
      snap_high_q    <= snap_high_d;
      last_score_q   <= last_score_d;
      last_high_q    <= last_high_d;
      valid_score_q  <= valid_score_d;
      valid_high_q   <= valid_high_d;
      dirty_score_q  <= dirty_score_d;
      dirty_high_q   <= dirty_high_d;
      bcd_q          <= bcd_d;
      bin_q          <= bin_d;
      iter_q         <= iter_d;
      score_digits_q <= score_digits_d;
      high_digits_q  <= high_digits_d;
      busy_q         <= busy_d;
      update_done_q  <= update_done_d;
    end
  end

  assign score_digits      = score_digits_q;
  assign high_score_digits = high_digits_q;
  assign busy              = busy_q;
  assign update_done       = update_done_q;

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Testbench for score_digit_scheduler: cycle-exact directed sequences for the
// round timing cases, plus a table of boundary conversions.

module tb_score_digit_scheduler;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [13:0] score;
  logic [13:0] high_score;
  logic [15:0] score_digits;
  logic [15:0] high_score_digits;
  logic        busy;
  logic        update_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] score;
    logic [13:0] high;
    logic [15:0] exp_s;
    logic [15:0] exp_h;
  } vec_t;

  vec_t vecs[9];

  score_digit_scheduler #(
    .VALUE_W(14),
    .NUM_DIGITS(4),
    .MAX_VALUE(9999)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .score(score),
    .high_score(high_score),
    .score_digits(score_digits),
    .high_score_digits(high_score_digits),
    .busy(busy),
    .update_done(update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_s;
    logic [15:0] exp_h;
    logic        got;

    vecs[0] = '{14'd0,     14'd16383, 16'h0000, 16'h9999};
    vecs[1] = '{14'd1,     14'd9998,  16'h0001, 16'h9998};
    vecs[2] = '{14'd9,     14'd999,   16'h0009, 16'h0999};
    vecs[3] = '{14'd10,    14'd0,     16'h0010, 16'h0000};
    vecs[4] = '{14'd999,   14'd1,     16'h0999, 16'h0001};
    vecs[5] = '{14'd9998,  14'd9,     16'h9998, 16'h0009};
    vecs[6] = '{14'd16383, 14'd10,    16'h9999, 16'h0010};
    vecs[7] = '{14'd9999,  14'd10000, 16'h9999, 16'h9999};
    vecs[8] = '{14'd4321,  14'd8765,  16'h4321, 16'h8765};

    // Reset
    rst = 1'b1; frame_start = 1'b0; score = '0; high_score = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_score_digits", 32'(score_digits), 32'h0);
    check("rst_high_digits", 32'(high_score_digits), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_update_done", 32'(update_done), 32'h0);

    // Full round: both channels dirty
    score = 14'd1234; high_score = 14'd56; frame_start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      frame_start = 1'b0;
      exp_s = (k >= 17) ? 16'h1234 : 16'h0000;
      exp_h = (k >= 33) ? 16'h0056 : 16'h0000;
      check($sformatf("r1_busy_t%0d", k), 32'(busy), 32'(k <= 34));
      check($sformatf("r1_done_t%0d", k), 32'(update_done), 32'(k == 34));
      check($sformatf("r1_score_t%0d", k), 32'(score_digits), 32'(exp_s));
      check($sformatf("r1_high_t%0d", k), 32'(high_score_digits), 32'(exp_h));
    end

    // Unchanged values: empty round
    frame_start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      frame_start = 1'b0;
      check($sformatf("r2_busy_t%0d", k), 32'(busy), 32'(k <= 2));
      check($sformatf("r2_done_t%0d", k), 32'(update_done), 32'(k == 2));
      check($sformatf("r2_score_t%0d", k), 32'(score_digits), 32'h1234);
      check($sformatf("r2_high_t%0d", k), 32'(high_score_digits), 32'h0056);
    end

    // Saturated channels bypass the engine
    score = 14'd12000; high_score = 14'd9999; frame_start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      frame_start = 1'b0;
      exp_s = (k >= 3) ? 16'h9999 : 16'h1234;
      exp_h = (k >= 5) ? 16'h9999 : 16'h0056;
      check($sformatf("r3_busy_t%0d", k), 32'(busy), 32'(k <= 6));
      check($sformatf("r3_done_t%0d", k), 32'(update_done), 32'(k == 6));
      check($sformatf("r3_score_t%0d", k), 32'(score_digits), 32'(exp_s));
      check($sformatf("r3_high_t%0d", k), 32'(high_score_digits), 32'(exp_h));
    end

    // Pulses during a round collapse into one pending round; input change
    // mid-round is picked up only by that pending round.
    score = 14'd1; high_score = 14'd2; frame_start = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      tick();
      frame_start = (k == 5) || (k == 20);
      if (k >= 10) score = 14'd5;
      exp_s = (k < 17) ? 16'h9999 : ((k < 52) ? 16'h0001 : 16'h0005);
      exp_h = (k < 33) ? 16'h9999 : 16'h0002;
      check($sformatf("r4_busy_t%0d", k), 32'(busy),
            32'(((k >= 1) && (k <= 34)) || ((k >= 36) && (k <= 53))));
      check($sformatf("r4_done_t%0d", k), 32'(update_done), 32'((k == 34) || (k == 53)));
      check($sformatf("r4_score_t%0d", k), 32'(score_digits), 32'(exp_s));
      check($sformatf("r4_high_t%0d", k), 32'(high_score_digits), 32'(exp_h));
    end

    // Boundary conversion table
    for (int i = 0; i < 9; i++) begin
      score = vecs[i].score; high_score = vecs[i].high; frame_start = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
        tick();
        frame_start = 1'b0;
        if (update_done) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("vec%0d_done_seen", i), 32'(got), 32'h1);
      tick();
      check($sformatf("vec%0d_score", i), 32'(score_digits), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d_high", i), 32'(high_score_digits), 32'(vecs[i].exp_h));
    end

    // Reset mid-conversion, then reconversion of zero values
    score = 14'd77; high_score = 14'd88; frame_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      frame_start = 1'b0;
    end
    rst = 1'b1;
    tick();
    check("mid_rst_score", 32'(score_digits), 32'h0);
    check("mid_rst_high", 32'(high_score_digits), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(update_done), 32'h0);
    rst = 1'b0; score = 14'd0; high_score = 14'd0; frame_start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      frame_start = 1'b0;
      check($sformatf("r6_busy_t%0d", k), 32'(busy), 32'(k <= 34));
      check($sformatf("r6_done_t%0d", k), 32'(update_done), 32'(k == 34));
      check($sformatf("r6_score_t%0d", k), 32'(score_digits), 32'h0);
      check($sformatf("r6_high_t%0d", k), 32'(high_score_digits), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
